// File: rtl/flash_sample_reader.sv
// Fetches the flash word holding the current 16-bit sample on each audio tick and
// delivers the addressed half-word, holding the address generator while busy.
module flash_sample_reader #(
   parameter int unsigned FLASH_AW = 23,
   parameter int unsigned OVR_W    = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sample_tick,
   input  logic [24:0]         address,
   output logic                hold,
   output logic                flash_read,
   output logic [FLASH_AW-1:0] flash_address,
   output logic [3:0]          flash_byteenable,
   input  logic                flash_waitrequest,
   input  logic [31:0]         flash_readdata,
   input  logic                flash_readdatavalid,
   output logic [15:0]         audio_data,
   output logic                audio_valid,
   output logic [OVR_W-1:0]    overrun_count
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT} state_t;

   state_t              state_q, state_d;
   logic                pending_q, pending_d;
   logic                half_q, half_d;
   logic [FLASH_AW-1:0] addr_q, addr_d;
   logic [15:0]         data_q, data_d;
   logic [OVR_W-1:0]    ovr_q, ovr_d;
   logic                read_q, hold_q, valid_q;

   // Bit 24 of the sample address is outside the flash window.
   logic unused_addr_msb;
   assign unused_addr_msb = address[24];

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      half_d    = half_q;
      addr_d    = addr_q;
      data_d    = data_q;
      ovr_d     = ovr_q;
      case (state_q)
         S_IDLE: begin
            if (sample_tick || pending_q) begin
               addr_d    = address[FLASH_AW:1];
               half_d    = address[0];
               pending_d = 1'b0;
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            if (!flash_waitrequest) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flash_readdatavalid) begin
               data_d  = half_q ? flash_readdata[31:16] : flash_readdata[15:0];
               state_d = S_EMIT;
            end
         end
         S_EMIT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A tick while busy queues at most one fetch but is always counted.
      if (sample_tick && (state_q != S_IDLE)) begin
         pending_d = 1'b1;
         if (ovr_q != '1) ovr_d = ovr_q + OVR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         pending_q <= 1'b0;
         half_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         ovr_q     <= '0;
         read_q    <= 1'b0;
         hold_q    <= 1'b1;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         half_q    <= half_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         ovr_q     <= ovr_d;
         read_q    <= (state_d == S_REQ);
         hold_q    <= (state_d != S_EMIT);
         valid_q   <= (state_d == S_EMIT);
      end
   end

   assign hold             = hold_q;
   assign flash_read       = read_q;
   assign flash_address    = addr_q;
   assign flash_byteenable = 4'hF;
   assign audio_data       = data_q;
   assign audio_valid      = valid_q;
   assign overrun_count    = ovr_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader: the bench plays the Avalon slave and
// checks handshake timing, half-word selection, overrun queuing and reset abort.
module tb_flash_sample_reader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sample_tick;
   logic [24:0] address;
   logic        hold;
   logic        flash_read;
   logic [22:0] flash_address;
   logic [3:0]  flash_byteenable;
   logic        flash_waitrequest;
   logic [31:0] flash_readdata;
   logic        flash_readdatavalid;
   logic [15:0] audio_data;
   logic        audio_valid;
   logic [7:0]  overrun_count;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   flash_sample_reader #(.FLASH_AW(23), .OVR_W(8)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .sample_tick         (sample_tick),
      .address             (address),
      .hold                (hold),
      .flash_read          (flash_read),
      .flash_address       (flash_address),
      .flash_byteenable    (flash_byteenable),
      .flash_waitrequest   (flash_waitrequest),
      .flash_readdata      (flash_readdata),
      .flash_readdatavalid (flash_readdatavalid),
      .audio_data          (audio_data),
      .audio_valid         (audio_valid),
      .overrun_count       (overrun_count)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_tick(input logic [24:0] a);
      address     = a;
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
   endtask

   // Entered with flash_read expected high; holds waitrequest for ws cycles, returns
   // readdatavalid lat cycles after accept, pulsing nticks ticks while waiting.
   task automatic serve(input string nm, input int ws, input int lat, input int nticks,
                        input logic [31:0] rd, input logic [22:0] exp_fa,
                        input logic [15:0] exp_d);
      for (int i = 0; i <= ws; i++) begin
         n_chk++;
         if (flash_read !== 1'b1 || flash_address !== exp_fa || hold !== 1'b1)
            $display("FAIL %s req[%0d]: read=%b addr=%h hold=%b, expected read=1 addr=%h hold=1",
                     nm, i, flash_read, flash_address, hold, exp_fa);
         else n_pass++;
         flash_waitrequest = (i < ws);
         cyc();
      end
      flash_waitrequest = 1'b0;
      n_chk++;
      if (flash_read !== 1'b0) $display("FAIL %s read_drop: read=%b, expected 0", nm, flash_read);
      else n_pass++;
      for (int i = 0; i < lat - 1; i++) begin
         sample_tick = (i < nticks);
         cyc();
         sample_tick = 1'b0;
         n_chk++;
         if (audio_valid !== 1'b0 || hold !== 1'b1)
            $display("FAIL %s wait[%0d]: valid=%b hold=%b, expected valid=0 hold=1",
                     nm, i, audio_valid, hold);
         else n_pass++;
      end
      flash_readdatavalid = 1'b1;
      flash_readdata      = rd;
      cyc();
      flash_readdatavalid = 1'b0;
      flash_readdata      = 32'h0;
      n_chk++;
      if (audio_valid !== 1'b1 || hold !== 1'b0 || audio_data !== exp_d)
         $display("FAIL %s emit: valid=%b hold=%b data=%h, expected valid=1 hold=0 data=%h",
                  nm, audio_valid, hold, audio_data, exp_d);
      else n_pass++;
      cyc();
      n_chk++;
      if (audio_valid !== 1'b0 || hold !== 1'b1 || audio_data !== exp_d)
         $display("FAIL %s after_emit: valid=%b hold=%b data=%h, expected valid=0 hold=1 data=%h",
                  nm, audio_valid, hold, audio_data, exp_d);
      else n_pass++;
   endtask

   task automatic check_reset_values(input string nm);
      n_chk++;
      if (hold !== 1'b1 || flash_read !== 1'b0 || flash_address !== 23'h0 ||
          audio_data !== 16'h0 || audio_valid !== 1'b0 || overrun_count !== 8'h0 ||
          flash_byteenable !== 4'hF)
         $display("FAIL %s: hold=%b read=%b addr=%h data=%h valid=%b ovr=%0d be=%h, expected 1 0 0 0 0 0 f",
                  nm, hold, flash_read, flash_address, audio_data, audio_valid,
                  overrun_count, flash_byteenable);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cyc();
      cyc();
      check_reset_values("reset");
      reset_n = 1'b1;
      cyc();
      check_reset_values("reset_release");
   endtask

   task automatic test_zero_wait();
      start_tick(25'h0DF80);
      serve("zero_wait", 0, 1, 0, 32'hBEEF_1234, 23'h06FC0, 16'h1234);
   endtask

   task automatic test_upper_half();
      start_tick(25'h0DF81);
      serve("upper_half", 0, 1, 0, 32'hBEEF_1234, 23'h06FC0, 16'hBEEF);
   endtask

   task automatic test_spurious_rdv();
      flash_readdatavalid = 1'b1;
      flash_readdata      = 32'hFFFF_FFFF;
      cyc();
      flash_readdatavalid = 1'b0;
      flash_readdata      = 32'h0;
      cyc();
      n_chk++;
      if (audio_valid !== 1'b0 || audio_data !== 16'hBEEF || flash_read !== 1'b0)
         $display("FAIL spurious_rdv: valid=%b data=%h read=%b, expected 0 beef 0",
                  audio_valid, audio_data, flash_read);
      else n_pass++;
   endtask

   task automatic test_wait_states();
      // Bit 24 set to confirm it is ignored; address moves during the request.
      start_tick(25'h1234568);
      address = 25'h0000003;
      serve("wait_states", 5, 2, 0, 32'hCAFE_7E57, 23'h11A2B4, 16'h7E57);
   endtask

   task automatic test_overrun();
      test_reset();
      start_tick(25'h0000010);
      serve("overrun_main", 0, 10, 3, 32'h5555_AAAA, 23'h000008, 16'hAAAA);
      n_chk++;
      if (overrun_count !== 8'd3) $display("FAIL overrun_count: got %0d, expected 3", overrun_count);
      else n_pass++;
      address = 25'h0000013;
      cyc();
      serve("overrun_extra", 1, 1, 0, 32'h8001_7FFE, 23'h000009, 16'h8001);
      cyc();
      n_chk++;
      if (flash_read !== 1'b0 || overrun_count !== 8'd3)
         $display("FAIL overrun_single_queue: read=%b ovr=%0d, expected read=0 ovr=3",
                  flash_read, overrun_count);
      else n_pass++;
   endtask

   task automatic test_saturation();
      test_reset();
      start_tick(25'h0000000);
      flash_waitrequest = 1'b1;
      for (int i = 0; i < 300; i++) begin
         sample_tick = 1'b1;
         cyc();
         if (i == 253 || i == 254 || i == 299) begin
            n_chk++;
            if (overrun_count !== ((i == 253) ? 8'd254 : 8'd255))
               $display("FAIL saturation[%0d]: got %0d, expected %0d", i, overrun_count,
                        (i == 253) ? 254 : 255);
            else n_pass++;
         end
      end
      sample_tick = 1'b0;
      serve("sat_main", 0, 1, 0, 32'h0000_4321, 23'h0, 16'h4321);
      cyc();
      serve("sat_extra", 0, 1, 0, 32'h0000_1111, 23'h0, 16'h1111);
      n_chk++;
      if (overrun_count !== 8'd255) $display("FAIL saturation_hold: got %0d, expected 255", overrun_count);
      else n_pass++;
   endtask

   task automatic test_reset_wait();
      start_tick(25'h0DF80);
      flash_waitrequest = 1'b0;
      cyc();
      reset_n = 1'b0;
      #1;
      check_reset_values("reset_in_wait");
      cyc();
      reset_n = 1'b1;
      flash_readdatavalid = 1'b1;
      flash_readdata      = 32'h1234_5678;
      cyc();
      flash_readdatavalid = 1'b0;
      flash_readdata      = 32'h0;
      n_chk++;
      if (audio_valid !== 1'b0 || audio_data !== 16'h0 || flash_read !== 1'b0 || hold !== 1'b1)
         $display("FAIL late_rdv: valid=%b data=%h read=%b hold=%b, expected 0 0000 0 1",
                  audio_valid, audio_data, flash_read, hold);
      else n_pass++;
      start_tick(25'h0DF81);
      serve("after_reset", 0, 1, 0, 32'hBEEF_1234, 23'h06FC0, 16'hBEEF);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n             = 1'b0;
      sample_tick         = 1'b0;
      address             = '0;
      flash_waitrequest   = 1'b0;
      flash_readdata      = '0;
      flash_readdatavalid = 1'b0;
      test_reset();
      test_zero_wait();
      test_upper_half();
      test_spurious_rdv();
      test_wait_states();
      test_overrun();
      test_saturation();
      test_reset_wait();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/flash_sample_reader.md
# flash_sample_reader

Downstream stage of the address generator. On each audio sample tick it fetches the 32-bit flash word containing the current 16-bit sample address. It then selects the addressed half-word and presents it to the audio output path. While a fetch is pending it holds the address generator, and releases it for exactly one cycle per delivered sample so the address advances once per sample.

## Interface
Parameters:
- FLASH_AW, 23, flash word-address width; must equal the width of sample address bits [23:1].
- OVR_W, 8, overrun counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe at the audio rate, already synchronous to clk.
- address  in  25  sample address from the address generator, in 16-bit sample units; bit 24 ignored.
- hold  out  1  to the address generator (ORed externally with keyboard pause); 1 freezes the address.
- flash_read  out  1  Avalon-MM read request.
- flash_address  out  FLASH_AW  word address, equal to address[23:1] latched at request start.
- flash_byteenable  out  4  constant 4'hF.
- flash_waitrequest  in  1  slave stall; a request is accepted on a cycle with flash_read=1 and waitrequest=0.
- flash_readdata  in  32  read data.
- flash_readdatavalid  in  1  readdata qualifier.
- audio_data  out  16  last delivered sample, two's complement, registered.
- audio_valid  out  1  one-cycle pulse when audio_data updates.
- overrun_count  out  OVR_W  saturating count of ticks that arrived while busy.

## Operation
- FSM states:
  - IDLE: hold=1. On sample_tick or pending=1, latch word address address[23:1] and half select address[0], clear pending, then go to REQ.
  - REQ: flash_read=1 and flash_address stable. Stay in REQ while waitrequest=1. On waitrequest=0 (accepted), go to WAIT.
  - WAIT: flash_read=0. On readdatavalid, capture readdata[15:0] if the half select is 0, else readdata[31:16], then go to EMIT.
  - EMIT: audio_valid=1, audio_data=captured half, hold=0 for this cycle only, then return to IDLE.
- readdatavalid in IDLE, REQ or EMIT is ignored; no data is captured.
- sample_tick in REQ, WAIT or EMIT sets pending=1 and increments overrun_count, saturating at all-ones.
- A tick arriving while pending is already 1 increments the counter only; at most one fetch is queued.
- sample_tick in IDLE with pending=1 starts one fetch, and the counter is not incremented.
- Only one outstanding read at a time; no pipelining.
- address changes while in REQ or WAIT have no effect, because the latched value is used.
- flash_byteenable is always 4'hF.

## Timing
- Reset state:
  - FSM in IDLE and pending=0.
  - hold=1, flash_read=0, flash_address=0.
  - audio_data=0, audio_valid=0, overrun_count=0.
- All outputs are registered.
- Tick sampled in IDLE at edge T: flash_read=1 from T+1. It deasserts on the cycle after the one where waitrequest is sampled 0.
- Zero wait states: flash_read is high for exactly one cycle.
- readdatavalid sampled at edge D: audio_valid=1 and hold=0 during cycle D+1. The address generator advances at edge D+2.
- Minimum tick-to-audio_valid latency is 3 cycles: tick to REQ, REQ to WAIT, then valid at D with output at D+1, assuming readdatavalid one cycle after accept.
- Reset asserted mid-transaction:
  - Return to IDLE immediately and drop flash_read.
  - Any in-flight readdatavalid after reset is ignored.
  - The slave must tolerate the abandoned read.
- Counter at all-ones stays at all-ones.

## Test plan
- Zero-wait read: address=25'h0DF80, one tick, readdatavalid one cycle after accept with readdata=32'hBEEF_1234 -> flash_address=23'h06FC0, audio_data=16'h1234, audio_valid pulse 1 cycle, hold low exactly 1 cycle.
- Upper half: address=25'h0DF81, same readdata -> audio_data=16'hBEEF.
- Wait states: waitrequest=1 for 5 cycles -> flash_read held high with flash_address stable for 6 cycles, then one accept, then correct data.
- Overrun: 3 ticks during a 10-cycle WAIT -> overrun_count=3, exactly one extra fetch immediately after EMIT; 300 overruns -> overrun_count=255.
- Spurious readdatavalid in IDLE with readdata=32'hFFFF_FFFF -> audio_data unchanged, no audio_valid.
- Reset during WAIT -> all outputs at reset values immediately; a later readdatavalid is ignored; the next tick starts a clean fetch.
